// File: rtl/ip_extslot_pkg.sv
// Shared definitions for the MSX expanded-slot controller.
// Covers the response FSM encoding, the subslot register address and the page-to-subslot lookup.
package ip_extslot_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [15:0] EXTSLOT_ADDR = 16'hFFFF;

    // Each 16 KiB page p owns register bits [2p+1:2p].
    function automatic logic [1:0] page_subslot(input logic [7:0] ss_reg, input logic [1:0] page);
        return ss_reg[{page, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/ip_extslot_resp.sv
// Read-response engine: answers register reads directly and waits, with a timeout,
// for the selected subslot on all other reads.
module ip_extslot_resp
    import ip_extslot_pkg::*;
#(
    parameter int unsigned TIMEOUT      = 16,
    parameter logic [7:0]  DEFAULT_DATA = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_rise_i,
    input  logic        rd_i,
    input  logic        dec_i,
    input  logic        enabled_i,
    input  logic [1:0]  sel_i,
    input  logic [7:0]  reg_data_i,
    input  logic [3:0]  sub_read_ready_i,
    input  logic [31:0] sub_read_data_i,
    output logic        bus_read_ready_o,
    output logic [7:0]  bus_read_data_o
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (rd_rise_i) begin
                    if (dec_i) begin
                        state_d = RESP;
                        data_d  = reg_data_i;
                    end else if (!enabled_i) begin
                        state_d = RESP;
                        data_d  = DEFAULT_DATA;
                    end else begin
                        state_d = WAIT;
                        sel_d   = sel_i;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT: begin
                // A dropped read strobe wins over a same-cycle ready: the bus has gone away.
                if (!rd_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (sub_read_ready_i[sel_q]) begin
                    state_d = RESP;
                    data_d  = sub_read_data_i[{sel_q, 3'b000} +: 8];
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = RESP;
                    data_d  = DEFAULT_DATA;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_read_ready_o = (state_q == RESP);
        bus_read_data_o  = (state_q == RESP) ? data_q : 8'h00;
    end

endmodule

// File: rtl/ip_extslot_ex.sv
// MSX expanded-slot controller: subslot register at FFFFh, per-page strobe routing
// to up to four subslots, and read-response multiplexing back to the bus.
module ip_extslot_ex
    import ip_extslot_pkg::*;
#(
    parameter logic [3:0]  SUBSLOT_MASK = 4'b1111,
    parameter logic [7:0]  RESET_VALUE  = 8'h00,
    parameter bit          READ_INVERT  = 1'b1,
    parameter int unsigned TIMEOUT      = 16,
    parameter logic [7:0]  DEFAULT_DATA = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_slot_select,
    input  logic [15:0] bus_address,
    input  logic [7:0]  bus_write_data,
    input  logic        bus_memory_read,
    input  logic        bus_memory_write,
    output logic        bus_read_ready,
    output logic [7:0]  bus_read_data,
    output logic [3:0]  sub_memory_read,
    output logic [3:0]  sub_memory_write,
    input  logic [3:0]  sub_read_ready,
    input  logic [31:0] sub_read_data
);

    logic       rd, wr, rd_q, wr_q, rd_rise, wr_rise, dec, enabled;
    logic [1:0] sel;
    logic [7:0] reg_q, reg_data;
    logic [3:0] sub_rd_d, sub_wr_d, sub_rd_q, sub_wr_q;

    // Simultaneous read and write is illegal; the write is dropped.
    assign rd       = bus_memory_read & bus_slot_select;
    assign wr       = bus_memory_write & bus_slot_select & ~rd;
    assign rd_rise  = rd & ~rd_q;
    assign wr_rise  = wr & ~wr_q;
    assign dec      = (bus_address == EXTSLOT_ADDR);
    assign sel      = page_subslot(reg_q, bus_address[15:14]);
    assign enabled  = SUBSLOT_MASK[sel];
    assign reg_data = READ_INVERT ? ~reg_q : reg_q;

    always_comb begin
        sub_rd_d = '0;
        sub_wr_d = '0;
        for (int n = 0; n < 4; n++) begin
            sub_rd_d[n] = rd & ~dec & (sel == 2'(n)) & SUBSLOT_MASK[n];
            sub_wr_d[n] = wr & ~dec & (sel == 2'(n)) & SUBSLOT_MASK[n];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            reg_q    <= RESET_VALUE;
            sub_rd_q <= '0;
            sub_wr_q <= '0;
        end else begin
            rd_q     <= rd;
            wr_q     <= wr;
            sub_rd_q <= sub_rd_d;
            sub_wr_q <= sub_wr_d;
            if (wr_rise && dec) begin
                reg_q <= bus_write_data;
            end
        end
    end

    assign sub_memory_read  = sub_rd_q;
    assign sub_memory_write = sub_wr_q;

    ip_extslot_resp #(
        .TIMEOUT      (TIMEOUT),
        .DEFAULT_DATA (DEFAULT_DATA)
    ) u_resp (
        .clk              (clk),
        .reset            (reset),
        .rd_rise_i        (rd_rise),
        .rd_i             (rd),
        .dec_i            (dec),
        .enabled_i        (enabled),
        .sel_i            (sel),
        .reg_data_i       (reg_data),
        .sub_read_ready_i (sub_read_ready),
        .sub_read_data_i  (sub_read_data),
        .bus_read_ready_o (bus_read_ready),
        .bus_read_data_o  (bus_read_data)
    );

endmodule
